// File: rtl/pc_gen.sv
// Program-counter generator with valid/ready fetch handshake and branch/jump redirect.
// Optional macro PC_MISALIGN_TRAP_EN traps misaligned redirect targets instead of aligning them.
module pc_gen #(
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  branch_res,
   input  logic [ADDR_WIDTH-1:0] branch_target,
   input  logic                  jump_req,
   input  logic [ADDR_WIDTH-1:0] jump_target,
   input  logic                  stall,
   input  logic                  if_ready,
   output logic                  if_req,
   output logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  flush,
   output logic                  misalign_exc,
   output logic [ADDR_WIDTH-1:0] misalign_addr
);

`ifdef PC_MISALIGN_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic                  pend_q, pend_d;
   logic [ADDR_WIDTH-1:0] pend_tgt_q, pend_tgt_d;
   logic                  flush_nxt_q, flush_nxt_d;
   logic                  mis_exc_q, mis_exc_d;
   logic [ADDR_WIDTH-1:0] mis_addr_q, mis_addr_d;

   logic                  redirect;
   logic [ADDR_WIDTH-1:0] raw_tgt;
   logic [ADDR_WIDTH-1:0] tgt;
   logic                  tgt_bad;
   logic                  req;
   logic                  xfer;
   logic                  take;
   logic                  flush_now;

   always_comb begin
      redirect    = branch_res || jump_req;
      raw_tgt     = branch_res ? branch_target : jump_target;
      tgt_bad     = TRAP_EN && (raw_tgt[1:0] != 2'b00);
      tgt         = TRAP_EN ? raw_tgt : {raw_tgt[ADDR_WIDTH-1:2], 2'b00};
      state_d     = state_q;
      pc_d        = pc_q;
      pend_d      = pend_q;
      pend_tgt_d  = pend_tgt_q;
      flush_nxt_d = 1'b0;
      mis_exc_d   = 1'b0;
      mis_addr_d  = '0;
      req         = 1'b0;
      xfer        = 1'b0;
      take        = 1'b0;
      flush_now   = 1'b0;

      case (state_q)
         IDLE: state_d = FETCH;
         FETCH: begin
            req  = !stall;
            xfer = req && if_ready;
            take = redirect && !tgt_bad;
            if (redirect && tgt_bad) begin
               mis_exc_d  = 1'b1;
               mis_addr_d = raw_tgt;
            end
            if (take) begin
               // Redirect wins over stall; an accepted request in flight is wrong-path
               pc_d        = tgt;
               flush_now   = 1'b1;
               flush_nxt_d = xfer;
            end else if (xfer) begin
               pc_d = pc_q + ADDR_WIDTH'(4);
            end else if (req) begin
               state_d = HOLD;
            end
         end
         HOLD: begin
            req  = 1'b1;
            xfer = if_ready;
            take = redirect && !pend_q && !tgt_bad;
            if (redirect && !pend_q && tgt_bad) begin
               mis_exc_d  = 1'b1;
               mis_addr_d = raw_tgt;
            end
            if (take) flush_now = 1'b1;
            if (xfer) begin
               state_d = FETCH;
               if (take) begin
                  pc_d        = tgt;
                  flush_nxt_d = 1'b1;
               end else if (pend_q) begin
                  pc_d        = pend_tgt_q;
                  pend_d      = 1'b0;
                  flush_nxt_d = 1'b1;
               end else begin
                  pc_d = pc_q + ADDR_WIDTH'(4);
               end
            end else if (take) begin
               // Address must stay stable until accepted, so park the redirect
               pend_d     = 1'b1;
               pend_tgt_d = tgt;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         pend_q      <= 1'b0;
         pend_tgt_q  <= '0;
         flush_nxt_q <= 1'b0;
         mis_exc_q   <= 1'b0;
         mis_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         pend_q      <= pend_d;
         pend_tgt_q  <= pend_tgt_d;
         flush_nxt_q <= flush_nxt_d;
         mis_exc_q   <= mis_exc_d;
         mis_addr_q  <= mis_addr_d;
      end
   end

   assign if_req        = req && !rst;
   assign if_addr       = pc_q;
   assign flush         = (flush_now || flush_nxt_q) && !rst;
   assign misalign_exc  = mis_exc_q;
   assign misalign_addr = mis_addr_q;

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning the PC/target width.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port branch_res  in  1  taken conditional branch from the branch decision in EX.
REQ-006 SHALL have port branch_target  in  ADDR_WIDTH  branch destination.
REQ-007 SHALL have port jump_req  in  1  JAL/JALR redirect.
REQ-008 SHALL have port jump_target  in  ADDR_WIDTH  jump destination.
REQ-009 SHALL have port stall  in  1  hazard stall, blocks new fetch requests.
REQ-010 SHALL have port if_ready  in  1  instruction memory accepts request.
REQ-011 SHALL have port if_req  out  1  fetch request valid.
REQ-012 SHALL have port if_addr  out  ADDR_WIDTH  fetch address, equal to the PC register.
REQ-013 SHALL have port flush  out  1  kill IF/ID contents.
REQ-014 SHALL have port misalign_exc  out  1  misaligned-target exception pulse.
REQ-015 SHALL have port misalign_addr  out  ADDR_WIDTH  offending target.

Function
REQ-016 SHALL implement states IDLE, FETCH and HOLD; transfer = if_req && if_ready.
REQ-017 IDLE SHALL drive if_req=0 and SHALL go to FETCH unconditionally on the next cycle, so the first request is issued 1 cycle after rst deasserts.
REQ-018 FETCH SHALL drive if_req = !stall; on transfer the PC SHALL become PC+4 (modulo 2^ADDR_WIDTH, wrapping from 0xFFFF_FFFC to 0); with if_req high and no transfer, the block SHALL move to HOLD.
REQ-019 HOLD SHALL drive if_req=1 with if_addr stable regardless of stall; on transfer it SHALL go to FETCH with PC+4.
REQ-020 Redirect = branch_res || jump_req; target = branch_target when branch_res=1, else jump_target.
REQ-021 A redirect in FETCH SHALL set PC <= target, SHALL assert flush that cycle, and SHALL override stall.
REQ-022 If a transfer coincides with a FETCH redirect, flush SHALL also be asserted the following cycle (wrong-path response).
REQ-023 A redirect in HOLD SHALL assert flush, latch the target into a pending register and set pend; if_addr SHALL stay unchanged.
REQ-024 On transfer with pend=1, the block SHALL set PC <= pending target, clear pend, assert flush the next cycle, and go to FETCH.
REQ-025 Redirects while pend=1 SHALL be ignored (wrong-path).
REQ-026 Redirect and transfer in the same HOLD cycle SHALL behave as REQ-023 followed immediately by REQ-024.

Reset
REQ-027 While rst=1 the block SHALL set state=IDLE, PC=RESET_PC, pend=0, pending target=0, if_req=0, flush=0, misalign_exc=0 and misalign_addr=0.
REQ-028 Reset mid-HOLD SHALL abandon the outstanding request and the pending redirect with no flush.

Configuration
REQ-029 With macro PC_MISALIGN_TRAP_EN defined, a redirect target with [1:0]!=0 SHALL be suppressed (no PC change, no flush, no pend), and misalign_exc=1 with misalign_addr=target SHALL be registered for exactly one cycle.
REQ-030 With PC_MISALIGN_TRAP_EN undefined, target[1:0] SHALL be forced to 2'b00 and misalign_exc and misalign_addr SHALL be tied to 0.

Verification
REQ-031 Reset release with if_ready=1 -> if_req=1 from cycle 1 and if_addr sequence 0x0, 0x4, 0x8.
REQ-032 if_ready=0 for 3 cycles at 0x8 with stall pulsed -> if_addr holds 0x8 and if_req stays 1; advances to 0xC after acceptance.
REQ-033 branch_res=1, target 0x100, with a transfer at 0x10 -> flush high for 2 cycles and next if_addr=0x100.
REQ-034 Redirect to 0x200 during HOLD at 0x20, then a jump_req to 0x300 -> 0x20 is accepted, flush is pulsed, the next address is 0x200 and 0x300 is ignored.
REQ-035 branch_res and jump_req together (0x40/0x80) with stall=1 -> PC=0x40.
REQ-036 Target 0x102 -> with PC_MISALIGN_TRAP_EN: misalign_exc for 1 cycle with misalign_addr=0x102 and the PC unchanged; without it: PC=0x100.
